// File: rtl/decode_pkg.sv
// RV32I decode definitions: opcodes, class bit indices, decoded payload and the decode function.
// Build macro DECODE_M_EXT_EN makes OP with funct7=0x01 (M extension) legal.
package decode_pkg;

    localparam int unsigned CLASS_WIDTH = 11;

    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;

    typedef enum logic [3:0] {
        CLS_REG_ARITH, CLS_IMM_ARITH, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_IMM_JUMP,
        CLS_REG_JUMP, CLS_LOAD_UPPER, CLS_LOAD_UPPER_PC, CLS_ENV, CLS_FENCE
    } instr_class_e;

    typedef struct packed {
        logic [CLASS_WIDTH-1:0] cls;
        logic                   illegal;
        logic [31:0]            imm;
        logic                   imm_valid;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [4:0]             rd;
        logic                   rs1_valid;
        logic                   rs2_valid;
        logic                   rd_valid;
        logic [2:0]             funct3;
        logic                   funct3_valid;
        logic [6:0]             funct7;
        logic                   funct7_valid;
    } decoded_t;

    function automatic decoded_t decode_instr(input logic [31:0] instr);
        decoded_t               d;
        logic [6:0]             opc;
        logic [2:0]             f3;
        logic [6:0]             f7;
        logic                   legal;
        logic                   shift;
        logic                   fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
        logic [CLASS_WIDTH-1:0] cls;

        opc   = instr[6:0];
        f3    = instr[14:12];
        f7    = instr[31:25];
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        cls   = '0;
        legal = 1'b1;

        case (opc)
            OPC_OP: begin
                cls[CLS_REG_ARITH] = 1'b1;
                legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
`ifdef DECODE_M_EXT_EN
                if (f7 == 7'h01) legal = 1'b1;
`endif
            end
            OPC_OP_IMM: begin
                cls[CLS_IMM_ARITH] = 1'b1;
                legal = !shift || (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd5));
            end
            OPC_LOAD: begin
                cls[CLS_LOAD] = 1'b1;
                legal = (f3 != 3'd3) && (f3 < 3'd6);
            end
            OPC_STORE: begin
                cls[CLS_STORE] = 1'b1;
                legal = (f3 <= 3'd2);
            end
            OPC_BRANCH: begin
                cls[CLS_BRANCH] = 1'b1;
                legal = (f3 != 3'd2) && (f3 != 3'd3);
            end
            OPC_JAL:      cls[CLS_IMM_JUMP]      = 1'b1;
            OPC_JALR: begin
                cls[CLS_REG_JUMP] = 1'b1;
                legal = (f3 == 3'd0);
            end
            OPC_LUI:      cls[CLS_LOAD_UPPER]    = 1'b1;
            OPC_AUIPC:    cls[CLS_LOAD_UPPER_PC] = 1'b1;
            OPC_SYSTEM: begin
                cls[CLS_ENV] = 1'b1;
                legal = (instr == 32'h0000_0073) || (instr == 32'h0010_0073);
            end
            OPC_MISC_MEM: cls[CLS_FENCE]         = 1'b1;
            default:      legal                  = 1'b0;
        endcase
        legal = legal && (instr[1:0] == 2'b11);

        fmt_r = cls[CLS_REG_ARITH];
        fmt_i = cls[CLS_IMM_ARITH] | cls[CLS_LOAD] | cls[CLS_REG_JUMP] | cls[CLS_ENV] | cls[CLS_FENCE];
        fmt_s = cls[CLS_STORE];
        fmt_b = cls[CLS_BRANCH];
        fmt_u = cls[CLS_LOAD_UPPER] | cls[CLS_LOAD_UPPER_PC];
        fmt_j = cls[CLS_IMM_JUMP];

        d         = '0;
        d.cls     = legal ? cls : '0;
        d.illegal = !legal;
        d.rs1     = instr[19:15];
        d.rs2     = instr[24:20];
        d.rd      = instr[11:7];
        d.funct3  = f3;
        // Non-shift OP-IMM has no funct7 field; report zero so consumers can match on it
        d.funct7  = (legal && cls[CLS_IMM_ARITH] && !shift) ? 7'h00 : f7;

        if (!legal)     d.imm = '0;
        else if (fmt_i) d.imm = {{20{instr[31]}}, instr[31:20]};
        else if (fmt_s) d.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        else if (fmt_b) d.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        else if (fmt_u) d.imm = {instr[31:12], 12'h000};
        else if (fmt_j) d.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        else            d.imm = '0;

        d.imm_valid    = legal && !fmt_r;
        d.rs1_valid    = legal && (fmt_r | fmt_i | fmt_s | fmt_b);
        d.rs2_valid    = legal && (fmt_r | fmt_s | fmt_b);
        d.rd_valid     = legal && (d.rd != 5'd0) &&
                         (fmt_r | cls[CLS_IMM_ARITH] | cls[CLS_LOAD] | cls[CLS_REG_JUMP] | fmt_u | fmt_j);
        d.funct3_valid = legal && (fmt_r | fmt_i | fmt_s | fmt_b);
        d.funct7_valid = legal && (cls[CLS_REG_ARITH] | cls[CLS_IMM_ARITH]);
        return d;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready pipeline register: an output register plus one skid entry.
// in_ready comes straight from the skid-entry state; flush empties both entries.
module skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_nxt;
    logic [WIDTH-1:0] out_data_nxt;
    logic             skid_valid;
    logic             skid_valid_nxt;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] skid_data_nxt;
    logic             in_fire;
    logic             out_free;

    // Next-state: skid entry drains first, so order is preserved
    always_comb begin
        out_valid_nxt  = out_valid;
        out_data_nxt   = out_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        in_fire        = in_valid && !skid_valid;
        out_free       = !out_valid || out_ready;

        if (flush) begin
            out_valid_nxt  = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid_nxt  = 1'b1;
                out_data_nxt   = skid_data;
                skid_valid_nxt = 1'b0;
            end else begin
                out_valid_nxt = in_fire;
                if (in_fire) out_data_nxt = in_data;
            end
        end else if (in_fire) begin
            skid_valid_nxt = 1'b1;
            skid_data_nxt  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            out_valid  <= out_valid_nxt;
            out_data   <= out_data_nxt;
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
        end
    end

    assign in_ready = !skid_valid;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: combinational decode feeding a two-entry skid buffer.
// Build macro DECODE_M_EXT_EN (in decode_pkg) enables the M-extension funct7 on OP.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [31:0]            in_instr,
    input  logic [PC_WIDTH-1:0]    in_pc,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CLASS_WIDTH-1:0] out_class,
    output logic                   out_illegal,
    output logic [31:0]            out_imm,
    output logic                   out_imm_valid,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [4:0]             out_rd,
    output logic                   out_rs1_valid,
    output logic                   out_rs2_valid,
    output logic                   out_rd_valid,
    output logic [2:0]             out_funct3,
    output logic                   out_funct3_valid,
    output logic [6:0]             out_funct7,
    output logic                   out_funct7_valid,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam int unsigned PAYLOAD_WIDTH = $bits(decoded_t) + PC_WIDTH + TAG_WIDTH;

    decoded_t                 dec_in;
    decoded_t                 dec_out;
    logic [PAYLOAD_WIDTH-1:0] payload_out;

    assign dec_in = decode_instr(in_instr);

    skid_buffer #(.WIDTH(PAYLOAD_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({dec_in, in_pc, in_tag}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (payload_out)
    );

    assign {dec_out, out_pc, out_tag} = payload_out;

    assign out_class        = dec_out.cls;
    assign out_illegal      = dec_out.illegal;
    assign out_imm          = dec_out.imm;
    assign out_imm_valid    = dec_out.imm_valid;
    assign out_rs1          = dec_out.rs1;
    assign out_rs2          = dec_out.rs2;
    assign out_rd           = dec_out.rd;
    assign out_rs1_valid    = dec_out.rs1_valid;
    assign out_rs2_valid    = dec_out.rs2_valid;
    assign out_rd_valid     = dec_out.rd_valid;
    assign out_funct3       = dec_out.funct3;
    assign out_funct3_valid = dec_out.funct3_valid;
    assign out_funct7       = dec_out.funct7;
    assign out_funct7_valid = dec_out.funct7_valid;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios, then randomized traffic against a reference model.
// Honors DECODE_M_EXT_EN so the model tracks the build under test.
module tb_decode_stage;

`ifdef DECODE_M_EXT_EN
    localparam bit M_EXT = 1'b1;
`else
    localparam bit M_EXT = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] cls;
        logic        illegal;
        logic [31:0] imm;
        logic        imm_v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_v;
        logic        rs2_v;
        logic        rd_v;
        logic [2:0]  f3;
        logic        f3_v;
        logic [6:0]  f7;
        logic        f7_v;
        logic [31:0] pc;
        logic [3:0]  tag;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [3:0]  in_tag;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_class;
    logic        out_illegal;
    logic [31:0] out_imm;
    logic        out_imm_valid;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rs1_valid, out_rs2_valid, out_rd_valid;
    logic [2:0]  out_funct3;
    logic        out_funct3_valid;
    logic [6:0]  out_funct7;
    logic        out_funct7_valid;
    logic [31:0] out_pc;
    logic [3:0]  out_tag;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    decode_stage #(.PC_WIDTH(32), .TAG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_instr(in_instr), .in_pc(in_pc), .in_tag(in_tag),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_illegal(out_illegal),
        .out_imm(out_imm), .out_imm_valid(out_imm_valid),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rs1_valid(out_rs1_valid), .out_rs2_valid(out_rs2_valid), .out_rd_valid(out_rd_valid),
        .out_funct3(out_funct3), .out_funct3_valid(out_funct3_valid),
        .out_funct7(out_funct7), .out_funct7_valid(out_funct7_valid),
        .out_pc(out_pc), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Class index (0..10) of an opcode, -1 if not an RV32I base opcode
    function automatic int class_of(input logic [6:0] opc);
        case (opc)
            7'h33: return 0;  7'h13: return 1;  7'h03: return 2;  7'h23: return 3;
            7'h63: return 4;  7'h6F: return 5;  7'h67: return 6;  7'h37: return 7;
            7'h17: return 8;  7'h73: return 9;  7'h0F: return 10;
            default: return -1;
        endcase
    endfunction

    function automatic logic [6:0] opc_of(input int k);
        case (k)
            0: return 7'h33;  1: return 7'h13;  2: return 7'h03;  3: return 7'h23;
            4: return 7'h63;  5: return 7'h6F;  6: return 7'h67;  7: return 7'h37;
            8: return 7'h17;  9: return 7'h73;  default: return 7'h0F;
        endcase
    endfunction

    function automatic beat_t ref_model(input logic [31:0] w, input logic [31:0] pc, input logic [3:0] tag);
        beat_t b;
        int    k, f3, f7, v;
        bit    ok, is_r, is_i, is_s, is_b, is_u, is_j;
        b = '0;
        b.pc = pc;  b.tag = tag;
        b.rs1 = w[19:15];  b.rs2 = w[24:20];  b.rd = w[11:7];
        b.f3 = w[14:12];   b.f7 = w[31:25];
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        k  = class_of(w[6:0]);
        ok = (k >= 0);
        case (k)
            0: ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)) || (M_EXT && f7 == 1);
            1: if (f3 == 1) ok = (f7 == 0); else if (f3 == 5) ok = (f7 == 0 || f7 == 32);
            2: ok = !(f3 inside {3, 6, 7});
            3: ok = (f3 <= 2);
            4: ok = !(f3 inside {2, 3});
            6: ok = (f3 == 0);
            9: ok = (w == 32'h0000_0073) || (w == 32'h0010_0073);
            default: ;
        endcase
        if (!ok) begin
            b.illegal = 1'b1;
            return b;
        end
        b.cls = 11'(1 << k);
        is_r = (k == 0);
        is_i = (k inside {1, 2, 6, 9, 10});
        is_s = (k == 3);
        is_b = (k == 4);
        is_u = (k inside {7, 8});
        is_j = (k == 5);
        v = 0;
        if (is_i) v = int'(w[31:20]) - (w[31] ? 4096 : 0);
        if (is_s) v = int'({w[31:25], w[11:7]}) - (w[31] ? 4096 : 0);
        if (is_b) v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
        if (is_j) v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 - (w[31] ? (1 << 20) : 0);
        b.imm   = is_u ? (w & 32'hFFFF_F000) : 32'(v);
        b.imm_v = !is_r;
        b.rs1_v = is_r || is_i || is_s || is_b;
        b.rs2_v = is_r || is_s || is_b;
        b.rd_v  = (w[11:7] != 0) && (is_r || (k inside {1, 2, 6}) || is_u || is_j);
        b.f3_v  = is_r || is_i || is_s || is_b;
        b.f7_v  = (k == 0 || k == 1);
        if (k == 1 && !(f3 inside {1, 5})) b.f7 = 7'h00;
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel <= 10) w[6:0] = opc_of(sel);
        else if (sel == 11) w = ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0000_0073;
        else if (sel == 12) begin
            w[6:0] = 7'h33;
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: w[31:25] = 7'h01;
            endcase
        end else if (sel == 13) begin
            w[6:0]   = 7'h13;
            w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock of stimulus; scoreboard updated at the edge the beat is accepted
    task automatic drive(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
        logic fire;
        in_valid  = v;
        in_instr  = w;
        in_pc     = $urandom;
        in_tag    = 4'($urandom);
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        fire = v && in_ready;
        @(posedge clk);
        if (!rst || fl) exp_q.delete();
        else if (fire) exp_q.push_back(ref_model(w, in_pc, in_tag));
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic check_reset_state(input string tagname);
        logic [109:0] data;
        data = {out_class, out_illegal, out_imm, out_imm_valid, out_rs1, out_rs2, out_rd,
                out_rs1_valid, out_rs2_valid, out_rd_valid, out_funct3, out_funct3_valid,
                out_funct7, out_funct7_valid, out_pc, out_tag};
        check({tagname, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tagname, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tagname, "_data_zero"}, 64'(data != '0), 64'd0);
    endtask

    // Monitor: every presented beat must equal the scoreboard head; pop on transfer
    initial begin
        beat_t got;
        forever begin
            @(negedge clk);
            if (rst && out_valid) begin
                got = {out_class, out_illegal, out_imm, out_imm_valid, out_rs1, out_rs2, out_rd,
                       out_rs1_valid, out_rs2_valid, out_rd_valid, out_funct3, out_funct3_valid,
                       out_funct7, out_funct7_valid, out_pc, out_tag};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected none at %0t", got, $time);
                end else begin
                    if (got !== exp_q[0]) begin
                        errors++;
                        $display("FAIL beat: got %h expected %h at %0t", got, exp_q[0], $time);
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout: got no finish expected finish by %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b0;  flush = 1'b0;  in_valid = 1'b0;  out_ready = 1'b0;
        in_instr = '0;  in_pc = '0;  in_tag = '0;
        repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);
        check_reset_state("reset");
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("ready_after_reset", 64'(in_ready), 64'd1);

        drive(1'b1, 32'h0170_0793, 1'b1, 1'b0);
        check("addi_latency", 64'(out_valid), 64'd1);
        check("addi_class", 64'(out_class), 64'h002);
        check("addi_imm", 64'(out_imm), 64'h17);
        check("addi_rd", 64'({out_rd_valid, out_rd}), 64'h2F);

        drive(1'b1, 32'h4020_81B3, 1'b1, 1'b0);
        check("sub_valid", 64'(out_valid), 64'd1);
        check("sub_funct7_rd", 64'({out_funct7, out_rd}), 64'({7'h20, 5'd3}));
        drive(1'b1, 32'h0051_2423, 1'b1, 1'b0);
        check("sw_valid", 64'(out_valid), 64'd1);
        check("sw_imm_rs2_rdv", 64'({out_imm, out_rs2, out_rd_valid}), 64'({32'd8, 5'd5, 1'b0}));

        drive(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0);
        check("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
        drive(1'b1, 32'h1234_50B7, 1'b1, 1'b0);
        check("lui_imm", 64'(out_imm), 64'h1234_5000);
        drive(1'b1, 32'h0231_00B3, 1'b1, 1'b0);
        check("mul_illegal", 64'(out_illegal), 64'(!M_EXT));
        check("mul_funct7_valid", 64'(out_funct7_valid), 64'(M_EXT));
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("ones_illegal", 64'({out_illegal, out_class}), 64'h800);
        drain();

        // Back-pressure: two beats fill both entries, the third is refused
        drive(1'b1, 32'h0010_0093, 1'b0, 1'b0);
        check("stall_ready_first", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h0020_0113, 1'b0, 1'b0);
        check("stall_ready_drop", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h0030_0193, 1'b0, 1'b0);
        check("stall_ready_hold", 64'(in_ready), 64'd0);
        check("stall_depth", 64'(exp_q.size()), 64'd2);
        repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);
        drain();

        // Flush with both entries full
        drive(1'b1, 32'h0000_0073, 1'b0, 1'b0);
        drive(1'b1, 32'h0010_0073, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_000F, 1'b0, 1'b1);
        check_reset_state_lite("flush_full");
        // Flush discards the beat accepted in the same cycle
        drive(1'b1, 32'h0040_0213, 1'b0, 1'b0);
        drive(1'b1, 32'h0050_0293, 1'b1, 1'b1);
        check_reset_state_lite("flush_accept");
        repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0);
        drain();

        // Reset mid-stream
        drive(1'b1, 32'h0060_0313, 1'b0, 1'b0);
        drive(1'b1, 32'h0070_0393, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 32'h0080_0413, 1'b1, 1'b0);
        rst = 1'b1;
        check_reset_state("midreset");
        repeat (2) drive(1'b0, 32'h0, 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic check_reset_state_lite(input string tagname);
        check({tagname, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tagname, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tagname, "_queue"}, 64'(exp_q.size()), 64'd0);
    endtask

endmodule
